exponent_accelerator_onchip_ram_pipelined: RTL and testbench

Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It is the next generation of the accelerator's scratch memory and adds:
- configurable width, depth and read latency
- explicit read/readdatavalid handshake with waitrequest
- a hardware clear engine that zero-fills the array after reset or on request.

It sits between the interconnect and the exponent datapath as operand and result storage.

---
 rtl/exponent_accelerator_onchip_ram_pipelined_if.sv | 26 ++
 rtl/exponent_accelerator_onchip_ram_pipelined.sv | 180 ++++++++++++++++++
 tb/tb_exponent_accelerator_onchip_ram_pipelined.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exponent_accelerator_onchip_ram_pipelined_if.sv
// Avalon-MM slave bus bundle for the exponent accelerator scratch RAM.
// The master drives the request side; the slave returns waitrequest and read data.
interface exponent_accelerator_onchip_ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/exponent_accelerator_onchip_ram_pipelined.sv
// Single-port scratch RAM for the exponent accelerator with an Avalon-MM slave port.
// Features: byte-lane writes, 1- or 2-cycle pipelined reads, clock enable stall,
// and a clear engine that zero-fills the array after reset or on clear_req.
module exponent_accelerator_onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset_n,
  exponent_accelerator_onchip_ram_pipelined_if.slave bus,
  input  logic clken,
  input  logic clear_req,
  output logic busy
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  // ST_INIT only lives between reset release and the first enabled edge.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [IDX_W-1:0]       clr_cnt_r;
  logic [IDX_W-1:0]       clr_cnt_nxt_s;
  logic                   busy_r;

  logic [DATA_WIDTH-1:0]  mem_r [DEPTH];

  logic                   waitrequest_s;
  logic                   in_range_s;
  logic [IDX_W-1:0]       idx_s;
  logic                   wr_acc_s;
  logic                   rd_acc_s;
  logic                   clr_wr_s;
  logic [DATA_WIDTH-1:0]  rd_word_s;

  logic                   v1_r;
  logic [DATA_WIDTH-1:0]  d1_r;

  // Requests are refused during reset, while stalled, and whenever not READY.
  assign waitrequest_s = ~reset_n | ~clken | (state_r != ST_READY);
  assign idx_s         = bus.address[IDX_W-1:0];
  assign wr_acc_s      = bus.chipselect & bus.write & ~waitrequest_s;
  assign rd_acc_s      = bus.chipselect & bus.read & ~bus.write & ~waitrequest_s;
  assign clr_wr_s      = clken & (state_r == ST_CLEAR);

  // Addresses beyond DEPTH only exist when the array does not fill the address space.
  if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_range_chk
    assign in_range_s = (bus.address < ADDR_WIDTH'(DEPTH));
  end else begin : g_range_full
    assign in_range_s = 1'b1;
  end

  // Next-state and clear-counter logic; everything holds while clken is low.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    if (clken) begin
      case (state_r)
        ST_INIT: begin
          if (CLEAR_ON_RESET != 0) begin
            state_nxt_s = ST_CLEAR;
          end else begin
            state_nxt_s = ST_READY;
          end
        end
        ST_READY: begin
          if (clear_req) begin
            state_nxt_s = ST_CLEAR;
          end else begin
            state_nxt_s = ST_READY;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_r == LAST_IDX) begin
            state_nxt_s   = ST_READY;
            clr_cnt_nxt_s = {IDX_W{1'b0}};
          end else begin
            state_nxt_s   = ST_CLEAR;
            clr_cnt_nxt_s = clr_cnt_r + ONE_IDX;
          end
        end
        default: begin
          state_nxt_s   = ST_INIT;
          clr_cnt_nxt_s = {IDX_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s   = state_r;
      clr_cnt_nxt_s = clr_cnt_r;
    end
  end

  // State, clear counter and registered busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_INIT;
      clr_cnt_r <= {IDX_W{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
      busy_r    <= (state_nxt_s == ST_CLEAR);
    end
  end

  // Array write port: clear engine zero-fill, otherwise byte-lane host writes.
  always_ff @(posedge clk) begin
    if (clr_wr_s) begin
      mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_acc_s && in_range_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.byteenable[b]) begin
          mem_r[idx_s][b*8 +: 8] <= bus.writedata[b*8 +: 8];
        end
      end
    end
  end

  // Read word selection; out-of-range reads return zero.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    if (in_range_s) begin
      rd_word_s = mem_r[idx_s];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
  end

  // First read stage: capture the word on acceptance; data holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r <= 1'b0;
      d1_r <= {DATA_WIDTH{1'b0}};
    end else if (clken) begin
      v1_r <= rd_acc_s;
      if (rd_acc_s) begin
        d1_r <= rd_word_s;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2_r;
    logic [DATA_WIDTH-1:0] d2_r;

    // Second read stage, frozen together with the first when clken is low.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_r <= 1'b0;
        d2_r <= {DATA_WIDTH{1'b0}};
      end else if (clken) begin
        v2_r <= v1_r;
        if (v1_r) begin
          d2_r <= d1_r;
        end
      end
    end

    assign bus.readdatavalid = v2_r;
    assign bus.readdata      = d2_r;
  end else begin : g_lat1
    assign bus.readdatavalid = v1_r;
    assign bus.readdata      = d1_r;
  end

  assign bus.waitrequest = waitrequest_s;
  assign busy            = busy_r;

endmodule

// File: tb/tb_exponent_accelerator_onchip_ram_pipelined.sv
// Directed bench for the scratch RAM: DEPTH=16 in a 5-bit address space,
// READ_LATENCY=2, clear on reset enabled.
module tb_exponent_accelerator_onchip_ram_pipelined;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int RL    = 2;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic clken     = 1'b1;
  logic clear_req = 1'b0;
  logic busy;

  int tests = 0;
  int fails = 0;

  exponent_accelerator_onchip_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  exponent_accelerator_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if),
    .clken(clken),
    .clear_req(clear_req),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic        cs;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs [17];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus;
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.byteenable = 4'h0;
    bus_if.writedata  = 32'h0;
    bus_if.address    = 5'd0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d, input logic cs);
    bus_if.address    = a;
    bus_if.byteenable = be;
    bus_if.writedata  = d;
    bus_if.chipselect = cs;
    bus_if.write      = 1'b1;
    bus_if.read       = 1'b0;
    step();
    idle_bus();
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string name);
    int lat;
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    #1;
    check({name, "_wait"}, 32'(bus_if.waitrequest), 32'd0);
    step();
    idle_bus();
    lat = 1;
    while (!bus_if.readdatavalid && lat < 10) begin
      step();
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(RL));
    check({name, "_data"}, bus_if.readdata, exp);
  endtask

  task automatic measure_clear(output int nb, output int nbad);
    nb   = 0;
    nbad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy) nb++;
      if (busy && !bus_if.waitrequest) nbad++;
      if (bus_if.readdatavalid) nbad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int nbad;
    int pulses;
    logic [31:0] e;

    vecs[0]  = '{1'b1, 1'b1, 5'd5,  4'hF, 32'hAABBCCDD};
    vecs[1]  = '{1'b1, 1'b1, 5'd5,  4'h5, 32'h11223344};
    vecs[2]  = '{1'b0, 1'b1, 5'd5,  4'h0, 32'hAA22CC44};
    vecs[3]  = '{1'b1, 1'b1, 5'd4,  4'hF, 32'h12345678};
    vecs[4]  = '{1'b1, 1'b1, 5'd20, 4'hF, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 1'b1, 5'd20, 4'h0, 32'h00000000};
    vecs[6]  = '{1'b0, 1'b1, 5'd4,  4'h0, 32'h12345678};
    vecs[7]  = '{1'b1, 1'b1, 5'd7,  4'h8, 32'hFFEEDDCC};
    vecs[8]  = '{1'b1, 1'b1, 5'd7,  4'h2, 32'h0000AB00};
    vecs[9]  = '{1'b1, 1'b1, 5'd7,  4'h0, 32'hFFFFFFFF};
    vecs[10] = '{1'b0, 1'b1, 5'd7,  4'h0, 32'hFF00AB00};
    vecs[11] = '{1'b1, 1'b1, 5'd15, 4'hF, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 1'b1, 5'd15, 4'h0, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 1'b0, 5'd15, 4'hF, 32'h00000000};
    vecs[14] = '{1'b0, 1'b1, 5'd15, 4'h0, 32'hCAFEF00D};
    vecs[15] = '{1'b0, 1'b1, 5'd31, 4'h0, 32'h00000000};
    vecs[16] = '{1'b0, 1'b1, 5'd0,  4'h0, 32'h00000000};

    idle_bus();
    repeat (3) step();
    check("rst_wait",  32'(bus_if.waitrequest),   32'd1);
    check("rst_rdv",   32'(bus_if.readdatavalid), 32'd0);
    check("rst_rdata", bus_if.readdata,           32'd0);
    check("rst_busy",  32'(busy),                 32'd0);

    // Power-up clear
    reset_n = 1'b1;
    measure_clear(nb, nbad);
    check("pwr_clear_len", 32'(nb),   32'd16);
    check("pwr_clear_bad", 32'(nbad), 32'd0);

    // Preload non-zero data, then reset and confirm the fill wipes it
    for (int k = 0; k < DEPTH; k++) do_write(5'(k), 4'hF, 32'hA5A50000 | 32'(k), 1'b1);
    do_read(5'd6, 32'hA5A50006, "preload");
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    measure_clear(nb, nbad);
    check("rst_clear_len", 32'(nb),   32'd16);
    check("rst_clear_bad", 32'(nbad), 32'd0);
    for (int k = 0; k < DEPTH; k++) do_read(5'(k), 32'h0, $sformatf("zero%0d", k));

    // Table-driven single transactions
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].cs);
      end else begin
        do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      end
    end

    // Back-to-back reads of k*3
    for (int k = 0; k < 4; k++) do_write(5'(k), 4'hF, 32'(k * 3), 1'b1);
    for (int s = 1; s <= 8; s++) begin
      if (s <= 4) begin
        bus_if.address    = 5'(s - 1);
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
      end else begin
        idle_bus();
      end
      step();
      check($sformatf("pipe_rdv%0d", s), 32'(bus_if.readdatavalid), (s >= 2 && s <= 5) ? 32'd1 : 32'd0);
      if (s >= 2 && s <= 5) begin
        e = 32'((s - 2) * 3);
        check($sformatf("pipe_data%0d", s), bus_if.readdata, e);
      end else if (s > 5) begin
        check($sformatf("pipe_hold%0d", s), bus_if.readdata, 32'd9);
      end
    end

    // clken stall mid-latency
    bus_if.address    = 5'd2;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    step();
    idle_bus();
    pulses = 0;
    clken  = 1'b0;
    #1;
    check("stall_wait", 32'(bus_if.waitrequest), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_if.readdatavalid) pulses++;
    end
    clken = 1'b1;
    step();
    check("stall_rdv",  32'(bus_if.readdatavalid), 32'd1);
    check("stall_data", bus_if.readdata,           32'd6);
    if (bus_if.readdatavalid) pulses++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_if.readdatavalid) pulses++;
    end
    check("stall_pulses", 32'(pulses), 32'd1);

    // read and write together: write only
    bus_if.address    = 5'd9;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    bus_if.write      = 1'b1;
    bus_if.byteenable = 4'hF;
    bus_if.writedata  = 32'h00000055;
    step();
    idle_bus();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_if.readdatavalid) pulses++;
    end
    check("rw_no_rdv", 32'(pulses), 32'd0);
    do_read(5'd9, 32'h00000055, "rw_data");

    // clear_req with a read in flight; repeated clear_req ignored
    bus_if.address    = 5'd3;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    step();
    idle_bus();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clr_inflight_rdv",  32'(bus_if.readdatavalid), 32'd1);
    check("clr_inflight_data", bus_if.readdata,           32'd9);
    nb = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      clear_req = (i == 4);
      step();
      if (busy) nb++;
    end
    clear_req = 1'b0;
    check("clr_req_len", 32'(nb), 32'd16);
    do_read(5'd3, 32'h0, "clr_after3");
    do_read(5'd5, 32'h0, "clr_after5");

    // Reset with a read in flight
    do_write(5'd8, 4'hF, 32'h00000077, 1'b1);
    bus_if.address    = 5'd8;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    step();
    idle_bus();
    reset_n = 1'b0;
    #1;
    check("rstfl_rdv",   32'(bus_if.readdatavalid), 32'd0);
    check("rstfl_rdata", bus_if.readdata,           32'd0);
    check("rstfl_wait",  32'(bus_if.waitrequest),   32'd1);
    step();
    reset_n = 1'b1;
    measure_clear(nb, nbad);
    check("rstfl_clear_len", 32'(nb),   32'd16);
    check("rstfl_no_rdv",    32'(nbad), 32'd0);

    // Reset at clear cycle 7 restarts a full fill
    do_write(5'd10, 4'hF, 32'h00001234, 1'b1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (6) step();
    check("mid_busy7", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    step();
    reset_n = 1'b1;
    measure_clear(nb, nbad);
    check("mid_clear_len", 32'(nb),   32'd16);
    check("mid_clear_bad", 32'(nbad), 32'd0);
    do_read(5'd10, 32'h0, "mid_after10");
    do_read(5'd15, 32'h0, "mid_after15");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
